ms_tmr32_dtg: RTL and testbench
===============================

// Module: ms_tmr32_dtg
// PURPOSE
//  Dead-time generator downstream of the ms_tmr32 timer core.
//  Consumes the core's single-ended pwm_out and produces complementary high-side/low-side gate drives.
//  Inserts programmable dead time (both sides off) on every transition, with per-side polarity control and a latched fault shutdown.
//  Instantiated beside ms_tmr32 in the wrapper; its control inputs are driven from CTRL-style registers.
// PARAMETERS
//  DT_W  8  width of the dead-time values and of the internal down-counter
// PORTS
//  clk         in   1     system clock
//  rst_n       in   1     asynchronous active-low reset
//  en          in   1     block enable; 0 forces IDLE (both sides off)
//  pwm_in      in   1     PWM from ms_tmr32 pwm_out; clk-synchronous
//  dt_rise     in   DT_W  dead-time cycles inserted before pwm_h turns on
//  dt_fall     in   DT_W  dead-time cycles inserted before pwm_l turns on
//  pol_h       in   1     pwm_h polarity: 0 = active-high, 1 = active-low
//  pol_l       in   1     pwm_l polarity: 0 = active-high, 1 = active-low
//  fault       in   1     synchronous fault level; 1 forces shutdown
//  fault_clr   in   1     one-cycle pulse; releases a latched fault
//  pwm_h       out  1     high-side drive = h_on_q ^ pol_h
//  pwm_l       out  1     low-side drive  = l_on_q ^ pol_l
//  dt_active   out  1     1 while in DT_RISE or DT_FALL
//  fault_flag  out  1     1 while in FAULT (latched)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pwm_q=0, state=IDLE, cnt=0.
//   - h_on_q=l_on_q=0, so pwm_h=pol_h and pwm_l=pol_l.
//   - dt_active=0, fault_flag=0.
//   - Applies immediately, including mid-dead-time.
//  Input stage: pwm_q <= pwm_in every edge. The FSM acts only on pwm_q.
//  States: IDLE, LOW_ON, DT_RISE, HIGH_ON, DT_FALL, FAULT.
//   - h_on_q=1 only in HIGH_ON; l_on_q=1 only in LOW_ON.
//   - h_on_q and l_on_q are flops updated on the same edge as state.
//  Priority per edge: fault=1 > en=0 > normal transitions.
//   - fault=1 in any state -> FAULT.
//   - else en=0 -> IDLE (FAULT is unaffected by en).
//  Normal transitions (D = dt_rise or dt_fall, sampled when the transition is taken):
//   - IDLE: pwm_q=1 -> DT_RISE with cnt=dt_rise-1, or HIGH_ON if dt_rise=0.
//     pwm_q=0 -> DT_FALL with cnt=dt_fall-1, or LOW_ON if dt_fall=0.
//   - LOW_ON: pwm_q=1 -> DT_RISE with cnt=dt_rise-1, or HIGH_ON directly if dt_rise=0.
//   - HIGH_ON: pwm_q=0 -> DT_FALL with cnt=dt_fall-1, or LOW_ON directly if dt_fall=0.
//   - DT_RISE: pwm_q=0 -> LOW_ON (aborted pulse; high side never turned on).
//     else cnt=0 -> HIGH_ON; else cnt <= cnt-1.
//   - DT_FALL: pwm_q=1 -> HIGH_ON (aborted); else cnt=0 -> LOW_ON; else cnt-1.
//   - FAULT: fault_clr=1 and fault=0 -> IDLE. fault_clr while fault=1 is ignored.
//  Timing:
//   - pwm_in edge sampled at edge E0 -> the active side turns off at E1.
//   - The opposite side turns on at E(1+D). Both sides are off for exactly D cycles.
//   - D=0 gives pure complementary output with 2-cycle latency from pwm_in.
//  Dead-time values:
//   - Changing dt_rise/dt_fall mid-count has no effect until the next load.
//   - D = 2^DT_W-1 is legal; no wrap occurs because cnt only decrements from D-1 to 0.
//  Invariant: h_on_q & l_on_q is never 1, in any state or input sequence.
// TESTING
//  1 dt_rise=3, dt_fall=5, pol=0, pwm_in period 20 (10 high):
//    pwm_l falls 2 cycles after the pwm_in rise, pwm_h rises 3 cycles later.
//    On pwm_in fall, pwm_h falls and pwm_l rises 5 cycles later; never both 1.
//  2 dt_rise=dt_fall=0: pwm_h == ~pwm_l in steady state, each lagging pwm_in by 2 cycles; dt_active stays 0.
//  3 dt_rise=4, pwm_in high for 2 cycles: pwm_h never asserts.
//    pwm_l goes low for 2 cycles, then back high; dt_active=1 for those 2 cycles.
//  4 fault=1 during HIGH_ON: next edge pwm_h=pwm_l=0, fault_flag=1.
//    fault_clr while fault=1: no change.
//    fault=0 then fault_clr: IDLE, then the dead-time entry path resumes.
//  5 pol_h=pol_l=1: reset gives pwm_h=pwm_l=1; scenario 1 waveforms are exactly inverted.
//  6 rst_n=0 mid DT_RISE: outputs inactive immediately.
//    en=0 during HIGH_ON: IDLE on the next edge with both sides off.

Source files
------------

// File: rtl/ms_tmr32_dtg_if.sv
// Control and gate-drive bundle between the timer wrapper and the dead-time generator.
interface ms_tmr32_dtg_if #(
  parameter int unsigned DT_W = 8
);
  logic            en;
  logic            pwm_in;
  logic [DT_W-1:0] dt_rise;
  logic [DT_W-1:0] dt_fall;
  logic            pol_h;
  logic            pol_l;
  logic            fault;
  logic            fault_clr;
  logic            pwm_h;
  logic            pwm_l;
  logic            dt_active;
  logic            fault_flag;

  // Wrapper side: drives controls, observes drives and status.
  modport master (
    output en, pwm_in, dt_rise, dt_fall, pol_h, pol_l, fault, fault_clr,
    input  pwm_h, pwm_l, dt_active, fault_flag
  );

  // Dead-time generator side.
  modport slave (
    input  en, pwm_in, dt_rise, dt_fall, pol_h, pol_l, fault, fault_clr,
    output pwm_h, pwm_l, dt_active, fault_flag
  );
endinterface

// File: rtl/ms_tmr32_dtg.sv
// Dead-time generator: turns the single-ended timer PWM into complementary
// high/low gate drives with programmable break-before-make gaps, per-side
// polarity and a latched fault shutdown.
module ms_tmr32_dtg #(
  parameter int unsigned DT_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  ms_tmr32_dtg_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOW_ON  = 3'd1,
    DT_RISE = 3'd2,
    HIGH_ON = 3'd3,
    DT_FALL = 3'd4,
    FAULT   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            pwm_q;
  logic            h_on_q, l_on_q;

  // Next state and dead-time counter; fault beats disable beats normal flow.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.fault) begin
      state_d = FAULT;
    end else if (!bus.en && (state_q != FAULT)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, LOW_ON, HIGH_ON: begin
          if (pwm_q && (state_q != HIGH_ON)) begin
            if (bus.dt_rise == '0) begin
              state_d = HIGH_ON;
            end else begin
              state_d = DT_RISE;
              cnt_d   = bus.dt_rise - DT_W'(1);
            end
          end else if (!pwm_q && (state_q != LOW_ON)) begin
            if (bus.dt_fall == '0) begin
              state_d = LOW_ON;
            end else begin
              state_d = DT_FALL;
              cnt_d   = bus.dt_fall - DT_W'(1);
            end
          end
        end
        DT_RISE: begin
          if (!pwm_q) begin
            state_d = LOW_ON;
          end else if (cnt_q == '0) begin
            state_d = HIGH_ON;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        DT_FALL: begin
          if (pwm_q) begin
            state_d = HIGH_ON;
          end else if (cnt_q == '0) begin
            state_d = LOW_ON;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        FAULT: begin
          if (bus.fault_clr) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counter, input sample and side enables share one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pwm_q   <= 1'b0;
      h_on_q  <= 1'b0;
      l_on_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwm_q   <= bus.pwm_in;
      h_on_q  <= (state_d == HIGH_ON);
      l_on_q  <= (state_d == LOW_ON);
    end
  end

  // Polarity is applied after the enable flops so it follows the control bit directly.
  assign bus.pwm_h      = h_on_q ^ bus.pol_h;
  assign bus.pwm_l      = l_on_q ^ bus.pol_l;
  assign bus.dt_active  = (state_q == DT_RISE) || (state_q == DT_FALL);
  assign bus.fault_flag = (state_q == FAULT);

endmodule

// File: tb/tb_ms_tmr32_dtg.sv
// Directed bench for the dead-time generator.
module tb_ms_tmr32_dtg;

  localparam int unsigned DT_W = 8;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  ms_tmr32_dtg_if #(.DT_W(DT_W)) bus ();

  ms_tmr32_dtg #(.DT_W(DT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 20-cycle PWM period (10 high) starting from LOW_ON; dr/df must be < 10.
  task automatic run_period(input int dr, input int df, input logic pol);
    logic eh, el, ed;
    bus.dt_rise = DT_W'(dr);
    bus.dt_fall = DT_W'(df);
    bus.pol_h   = pol;
    bus.pol_l   = pol;
    bus.pwm_in  = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 10) bus.pwm_in = 1'b0;
      eh = (t >= 2 + dr) && (t <= 11);
      el = (t <= 1) || (t >= 12 + df);
      ed = ((t >= 2) && (t < 2 + dr)) || ((t >= 12) && (t < 12 + df));
      chk($sformatf("per_h_t%0d", t), 32'(bus.pwm_h), 32'(eh ^ pol));
      chk($sformatf("per_l_t%0d", t), 32'(bus.pwm_l), 32'(el ^ pol));
      chk($sformatf("per_dt_t%0d", t), 32'(bus.dt_active), 32'(ed));
      chk($sformatf("per_excl_t%0d", t), 32'((bus.pwm_h ^ pol) & (bus.pwm_l ^ pol)), 32'd0);
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.en        = 1'b1;
    bus.pwm_in    = 1'b0;
    bus.dt_rise   = DT_W'(3);
    bus.dt_fall   = DT_W'(5);
    bus.pol_h     = 1'b0;
    bus.pol_l     = 1'b0;
    bus.fault     = 1'b0;
    bus.fault_clr = 1'b0;

    // Reset state, both polarities.
    #3;
    chk("rst_h", 32'(bus.pwm_h), 32'd0);
    chk("rst_l", 32'(bus.pwm_l), 32'd0);
    chk("rst_dt", 32'(bus.dt_active), 32'd0);
    chk("rst_ff", 32'(bus.fault_flag), 32'd0);
    bus.pol_h = 1'b1;
    bus.pol_l = 1'b1;
    #1;
    chk("rst_pol_h", 32'(bus.pwm_h), 32'd1);
    chk("rst_pol_l", 32'(bus.pwm_l), 32'd1);
    bus.pol_h = 1'b0;
    bus.pol_l = 1'b0;
    tick();
    rst_n = 1'b1;

    // IDLE with pwm low settles in LOW_ON after dt_fall.
    for (int i = 0; i < 8; i++) tick();
    chk("init_l", 32'(bus.pwm_l), 32'd1);
    chk("init_h", 32'(bus.pwm_h), 32'd0);

    // Nominal dead time, then the same waveforms inverted, then zero dead time.
    run_period(3, 5, 1'b0);
    run_period(3, 5, 1'b0);
    run_period(3, 5, 1'b1);
    run_period(0, 0, 1'b0);
    run_period(3, 5, 1'b0);

    // Short pulse shorter than dt_rise: high side never turns on.
    bus.dt_rise = DT_W'(4);
    bus.pwm_in  = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 2) bus.pwm_in = 1'b0;
      chk($sformatf("abort_h_t%0d", t), 32'(bus.pwm_h), 32'd0);
      chk($sformatf("abort_l_t%0d", t), 32'(bus.pwm_l), 32'((t == 2 || t == 3) ? 0 : 1));
      chk($sformatf("abort_dt_t%0d", t), 32'(bus.dt_active), 32'((t == 2 || t == 3) ? 1 : 0));
    end

    // Maximum dead time: exactly 255 cycles off, no wrap.
    bus.dt_rise = DT_W'(255);
    bus.pwm_in  = 1'b1;
    for (int t = 1; t <= 258; t++) begin
      tick();
      if (t == 256) begin
        chk("max_h_256", 32'(bus.pwm_h), 32'd0);
        chk("max_dt_256", 32'(bus.dt_active), 32'd1);
      end
      if (t == 257) begin
        chk("max_h_257", 32'(bus.pwm_h), 32'd1);
        chk("max_dt_257", 32'(bus.dt_active), 32'd0);
      end
    end

    // Fault during HIGH_ON, ignored clear, en ignored, then recovery via dead time.
    bus.dt_rise = DT_W'(3);
    bus.fault   = 1'b1;
    tick();
    chk("flt_h", 32'(bus.pwm_h), 32'd0);
    chk("flt_l", 32'(bus.pwm_l), 32'd0);
    chk("flt_ff", 32'(bus.fault_flag), 32'd1);
    bus.fault_clr = 1'b1;
    tick();
    chk("flt_clr_blocked", 32'(bus.fault_flag), 32'd1);
    bus.fault_clr = 1'b0;
    bus.fault     = 1'b0;
    bus.en        = 1'b0;
    tick();
    chk("flt_latched", 32'(bus.fault_flag), 32'd1);
    bus.en        = 1'b1;
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk("flt_rel_ff", 32'(bus.fault_flag), 32'd0);
    chk("flt_rel_h", 32'(bus.pwm_h), 32'd0);
    chk("flt_rel_dt", 32'(bus.dt_active), 32'd0);
    tick();
    chk("flt_resume_dt", 32'(bus.dt_active), 32'd1);
    tick();
    tick();
    chk("flt_resume_h_off", 32'(bus.pwm_h), 32'd0);
    tick();
    chk("flt_resume_h_on", 32'(bus.pwm_h), 32'd1);

    // Disable from HIGH_ON drops both sides on the next edge.
    bus.en = 1'b0;
    tick();
    chk("dis_h", 32'(bus.pwm_h), 32'd0);
    chk("dis_l", 32'(bus.pwm_l), 32'd0);
    chk("dis_dt", 32'(bus.dt_active), 32'd0);
    bus.en = 1'b1;
    tick();
    chk("dis_resume_dt", 32'(bus.dt_active), 32'd1);
    tick();

    // Asynchronous reset mid DT_RISE.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_h", 32'(bus.pwm_h), 32'd0);
    chk("arst_l", 32'(bus.pwm_l), 32'd0);
    chk("arst_dt", 32'(bus.dt_active), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
